decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: 2-entry elastic buffer (head + skid) with combinational MIPS field decode of the head.
// Optional opcode legality check enabled by defining DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int I_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [I_SIZE-1:0] if_instruction,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [5:0]        id_function,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [1:0]        id_type,
  output logic [DATA_W-1:0] id_imm_ext,
  output logic [DATA_W-1:0] id_jump_target,
  output logic [DATA_W-1:0] id_pc,
  output logic              id_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [I_SIZE-1:0] headInstr_q, headInstr_d;
  logic [DATA_W-1:0] headPc_q, headPc_d;
  logic [I_SIZE-1:0] skidInstr_q, skidInstr_d;
  logic [DATA_W-1:0] skidPc_q, skidPc_d;

  logic push;
  logic pop;

  assign if_ready = (state_q != TWO);
  assign id_valid = (state_q != EMPTY);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  always_comb begin
    state_d     = state_q;
    headInstr_d = headInstr_q;
    headPc_d    = headPc_q;
    skidInstr_d = skidInstr_q;
    skidPc_d    = skidPc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            headInstr_d = if_instruction;
            headPc_d    = if_pc;
          end
        end
        ONE: begin
          // Simultaneous push and pop refills the head directly, keeping one-per-cycle throughput.
          if (push && pop) begin
            headInstr_d = if_instruction;
            headPc_d    = if_pc;
          end else if (push) begin
            state_d     = TWO;
            skidInstr_d = if_instruction;
            skidPc_d    = if_pc;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            headInstr_d = skidInstr_q;
            headPc_d    = skidPc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      headInstr_q <= '0;
      headPc_q    <= '0;
      skidInstr_q <= '0;
      skidPc_q    <= '0;
    end else begin
      state_q     <= state_d;
      headInstr_q <= headInstr_d;
      headPc_q    <= headPc_d;
      skidInstr_q <= skidInstr_d;
      skidPc_q    <= skidPc_d;
    end
  end

  assign id_opcode      = headInstr_q[31:26];
  assign id_rs          = headInstr_q[25:21];
  assign id_rt          = headInstr_q[20:16];
  assign id_rd          = headInstr_q[15:11];
  assign id_shamt       = headInstr_q[10:6];
  assign id_function    = headInstr_q[5:0];
  assign id_pc          = headPc_q;
  assign id_jump_target = {headPc_q[DATA_W-1:28], headInstr_q[25:0], 2'b00};

  always_comb begin
    case (id_opcode)
      6'h00:        id_type = 2'b00;
      6'h02, 6'h03: id_type = 2'b10;
      default:      id_type = 2'b01;
    endcase
  end

  // Logical immediates zero-extend; lui places the immediate in the upper half.
  always_comb begin
    id_imm_ext = '0;
    case (id_opcode)
      6'h0C, 6'h0D, 6'h0E: id_imm_ext[15:0]  = headInstr_q[15:0];
      6'h0F:               id_imm_ext[31:16] = headInstr_q[15:0];
      default:             id_imm_ext = {{(DATA_W-16){headInstr_q[15]}}, headInstr_q[15:0]};
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic legalOp;

  always_comb begin
    case (id_opcode)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: legalOp = 1'b1;
      default:                                         legalOp = 1'b0;
    endcase
  end

  assign id_illegal = id_valid && !legalOp;
`else
  assign id_illegal = 1'b0;
`endif

endmodule
